// File: rtl/pipeline_ctrl_gen.sv
// Pipeline controller: RAW hazard detection over HAZ_STAGES write stages, reset/flush/interrupt FSM, PC/fetch/decode controls.
// Outputs are combinational from state and inputs; optional forwarding enabled by defining PIPE_FORWARDING_EN.
module pipeline_ctrl_gen #(
    parameter int RADDR_W      = 5,
    parameter int HAZ_STAGES   = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int RST_CYCLES   = 2,
    localparam int FWD_W       = $clog2(HAZ_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [RADDR_W-1:0]            src_a,
    input  logic                          src_a_used,
    input  logic [RADDR_W-1:0]            src_b,
    input  logic                          src_b_used,
    input  logic [HAZ_STAGES*RADDR_W-1:0] wr_addr,
    input  logic [HAZ_STAGES-1:0]         wr_en,
    input  logic [HAZ_STAGES-1:0]         wr_late,
    input  logic                          branch_resolved,
    input  logic                          branch_taken,
    input  logic                          int_req,
    input  logic                          int_en,
    output logic                          pc_inc,
    output logic                          pc_load,
    output logic                          pc_reset,
    output logic                          fetch_hold,
    output logic                          imem_replay,
    output logic                          dec_nop,
    output logic                          int_ack,
    output logic [FWD_W-1:0]              fwd_a_sel,
    output logic [FWD_W-1:0]              fwd_b_sel,
    output logic [1:0]                    state_o,
    output logic [15:0]                   stall_count
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_INT   = 2'd3
    } state_t;

    localparam int CNT_MAX = (FLUSH_CYCLES > RST_CYCLES) ? FLUSH_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [HAZ_STAGES-1:0] match_a;
    logic [HAZ_STAGES-1:0] match_b;
    logic               hazard;
    logic               take_branch;
    logic               take_int;
    logic               stall;

    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 0; k < HAZ_STAGES; k++) begin
            match_a[k] = src_a_used & wr_en[k] & (wr_addr[k*RADDR_W +: RADDR_W] == src_a);
            match_b[k] = src_b_used & wr_en[k] & (wr_addr[k*RADDR_W +: RADDR_W] == src_b);
        end
    end

`ifdef PIPE_FORWARDING_EN
    // Only results not yet produced stall; anything else is forwarded from the youngest matching stage.
    always_comb begin
        hazard    = |((match_a | match_b) & wr_late);
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int k = HAZ_STAGES - 1; k >= 0; k--) begin
            if (match_a[k]) fwd_a_sel = FWD_W'(k + 1);
            if (match_b[k]) fwd_b_sel = FWD_W'(k + 1);
        end
    end
`else
    logic unused_late;
    assign unused_late = ^wr_late;
    assign hazard      = |(match_a | match_b);
    assign fwd_a_sel   = '0;
    assign fwd_b_sel   = '0;
`endif

    assign take_branch = (state == S_RUN) & branch_resolved & branch_taken;
    assign take_int    = (state == S_RUN) & ~take_branch & int_req & int_en;
    assign stall       = (state == S_RUN) & ~take_branch & ~take_int & hazard;
    assign state_o     = state;

    always_comb begin
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_reset    = 1'b0;
        fetch_hold  = 1'b0;
        imem_replay = 1'b0;
        dec_nop     = 1'b0;
        int_ack     = 1'b0;
        case (state)
            S_RESET: begin
                pc_reset = 1'b1;
                dec_nop  = 1'b1;
            end
            S_RUN: begin
                if (take_branch) begin
                    pc_load = 1'b1;
                    dec_nop = 1'b1;
                end else if (stall) begin
                    fetch_hold  = 1'b1;
                    imem_replay = 1'b1;
                    dec_nop     = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
            end
            S_FLUSH: begin
                dec_nop = 1'b1;
                pc_inc  = 1'b1;
            end
            S_INT: begin
                int_ack = 1'b1;
                pc_load = 1'b1;
                dec_nop = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RESET;
            cnt         <= CNT_W'(RST_CYCLES);
            stall_count <= '0;
        end else begin
            if (stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
            case (state)
                S_RESET: begin
                    if (cnt == CNT_W'(1)) state <= S_RUN;
                    else                  cnt   <= cnt - CNT_W'(1);
                end
                S_RUN: begin
                    if (take_branch) begin
                        state <= S_FLUSH;
                        cnt   <= CNT_W'(FLUSH_CYCLES);
                    end else if (take_int) begin
                        state <= S_INT;
                    end
                end
                S_INT: begin
                    state <= S_FLUSH;
                    cnt   <= CNT_W'(FLUSH_CYCLES);
                end
                S_FLUSH: begin
                    if (cnt == CNT_W'(1)) state <= S_RUN;
                    else                  cnt   <= cnt - CNT_W'(1);
                end
                default: state <= S_RESET;
            endcase
        end
    end

endmodule
